// File: rtl/modulo_seq.sv
// Fixed-latency 16-bit unsigned divider producing remainder and quotient.
// Restoring division, one quotient bit per clock; divide-by-zero short-circuits.
//
// state | meaning
// IDLE  | waiting for modulo_start_i; operands are latched on the accepting edge
// CALC  | one restoring step per edge, 16 steps (one edge when divisor is zero)
// DONE  | results visible, modulo_ready_o high for this single cycle
module modulo_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        modulo_start_i,
  input  logic [15:0] op_a_i,
  input  logic [15:0] op_b_i,
  output logic        modulo_ready_o,
  output logic [15:0] res_o,
  output logic [15:0] quot_o,
  output logic        busy_o,
  output logic        div_zero_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [15:0] rem;
  logic [15:0] dvd;
  logic [15:0] dvs;

  logic [16:0] shifted;
  logic        fits;
  logic [15:0] rem_step;
  logic [15:0] dvd_step;

  // When the divisor fits, the true difference is below 2^16, so 16-bit
  // wrap-around subtraction is exact; bit 16 only matters for the compare.
  always_comb begin
    shifted  = {rem, dvd[15]};
    fits     = (shifted >= {1'b0, dvs});
    rem_step = fits ? (shifted[15:0] - dvs) : shifted[15:0];
    dvd_step = {dvd[14:0], fits};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (modulo_start_i) state_nxt = CALC;
      CALC: if (dvs == 16'd0 || cnt == 5'd15) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      rem        <= 16'd0;
      dvd        <= 16'd0;
      dvs        <= 16'd0;
      res_o      <= 16'd0;
      quot_o     <= 16'd0;
      div_zero_o <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (modulo_start_i) begin
            dvd <= op_a_i;
            dvs <= op_b_i;
            rem <= 16'd0;
            cnt <= 5'd0;
          end
        end
        CALC: begin
          if (dvs == 16'd0) begin
            res_o      <= dvd;
            quot_o     <= 16'hFFFF;
            div_zero_o <= 1'b1;
          end else begin
            rem <= rem_step;
            dvd <= dvd_step;
            cnt <= cnt + 5'd1;
            // results publish only on the final step so partial values stay hidden
            if (cnt == 5'd15) begin
              res_o      <= rem_step;
              quot_o     <= dvd_step;
              div_zero_o <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign modulo_ready_o = (state == DONE);
  assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_modulo_seq.sv
// Scoreboard bench for modulo_seq: the driver queues hand-computed results,
// a negedge monitor pops and compares on every ready pulse.
module tb_modulo_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        modulo_start_i = 1'b0;
  logic [15:0] op_a_i = 16'd0;
  logic [15:0] op_b_i = 16'd0;
  logic        modulo_ready_o;
  logic [15:0] res_o;
  logic [15:0] quot_o;
  logic        busy_o;
  logic        div_zero_o;

  modulo_seq dut (
    .clk            (clk),
    .rst            (rst),
    .modulo_start_i (modulo_start_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .modulo_ready_o (modulo_ready_o),
    .res_o          (res_o),
    .quot_o         (quot_o),
    .busy_o         (busy_o),
    .div_zero_o     (div_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [15:0] quot;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_res = 16'd0;
  logic [15:0] last_quot = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (modulo_ready_o) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res", int'(res_o), int'(e.res));
        check("quot", int'(quot_o), int'(e.quot));
        check("div_zero", int'(div_zero_o), int'(e.dz));
        check("latency", cyc - e.acc, e.lat);
        last_res  = e.res;
        last_quot = e.quot;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", 1, 0);
  endtask

  // Caller is at a negedge with the DUT idle; accept happens on the next edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [15:0] q,
                       input logic dz, input int lat);
    exp_t e;
    op_a_i = a;
    op_b_i = b;
    modulo_start_i = 1'b1;
    @(posedge clk);
    #1;
    modulo_start_i = 1'b0;
    op_a_i = ~a;
    op_b_i = b ^ 16'h5A5A;
    e.res = r; e.quot = q; e.dz = dz; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] r, input logic [15:0] q,
                     input logic dz, input int lat);
    wait_idle();
    issue(a, b, r, q, dz, lat);
    wait_idle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, int'(modulo_ready_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_res"}, int'(res_o), 0);
    check({tag, "_quot"}, int'(quot_o), 0);
    check({tag, "_dz"}, int'(div_zero_o), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");

    // reset wins over a simultaneous start
    modulo_start_i = 1'b1; op_a_i = 16'd9; op_b_i = 16'd3;
    @(negedge clk);
    rst = 1'b0; modulo_start_i = 1'b0;
    @(negedge clk);
    check("rst_priority_busy", int'(busy_o), 0);

    run(16'd48, 16'd18, 16'd12, 16'd2, 1'b0, 16);
    run(16'd7, 16'd0, 16'd7, 16'hFFFF, 1'b1, 1);
    run(16'd5, 16'd9, 16'd5, 16'd0, 1'b0, 16);
    run(16'hFFFF, 16'd1, 16'd0, 16'hFFFF, 1'b0, 16);
    run(16'hFFFF, 16'h8000, 16'h7FFF, 16'd1, 1'b0, 16);

    // start pulse mid-CALC must be ignored; outputs hold previous result
    wait_idle();
    issue(16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 16);
    repeat (3) @(negedge clk);
    op_a_i = 16'd9; op_b_i = 16'd2; modulo_start_i = 1'b1;
    @(negedge clk);
    modulo_start_i = 1'b0;
    check("hold_res", int'(res_o), int'(last_res));
    check("hold_quot", int'(quot_o), int'(last_quot));
    check("mid_busy", int'(busy_o), 1);
    wait_idle();
    repeat (20) @(negedge clk);

    // reset during CALC aborts with no ready pulse
    issue(16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 16);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run(16'd10, 16'd4, 16'd2, 16'd2, 1'b0, 16);

    // back-to-back chain, each issued the first idle cycle
    issue(16'd1071, 16'd462, 16'd147, 16'd2, 1'b0, 16);
    wait_idle();
    issue(16'd462, 16'd147, 16'd21, 16'd3, 1'b0, 16);
    wait_idle();
    issue(16'd147, 16'd21, 16'd0, 16'd7, 1'b0, 16);
    wait_idle();
    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modulo_seq.md
MODULO_SEQ -- requirements
Module: modulo_seq

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 16 bits and all operands are unsigned.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 modulo_start_i  input  1  request pulse; it SHALL be sampled only in IDLE.
REQ-005 op_a_i  input  16  dividend; it SHALL be captured on the accepting edge.
REQ-006 op_b_i  input  16  divisor; it SHALL be captured on the accepting edge.
REQ-007 modulo_ready_o  output  1  completion pulse; it SHALL be high only in the DONE state.
REQ-008 res_o  output  16  remainder, op_a mod op_b.
REQ-009 quot_o  output  16  quotient, op_a div op_b.
REQ-010 busy_o  output  1  high in the CALC and DONE states.
REQ-011 div_zero_o  output  1  high when the completed operation had op_b = 0.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and DONE, with a 5-bit iteration counter.
REQ-013 In IDLE with modulo_start_i=1, the edge (E0) SHALL latch op_a_i and op_b_i, clear the partial remainder and the counter, and enter CALC.
REQ-014 In CALC, each edge SHALL perform one restoring step:
- shift the 17-bit partial remainder left and bring in the dividend MSB;
- if the result is >= the divisor, subtract the divisor and shift 1 into the quotient, otherwise shift in 0.
REQ-015 CALC SHALL run exactly 16 steps, on edges E1..E16, regardless of operand values (fixed latency).
REQ-016 After E16 the FSM SHALL be in DONE, and modulo_ready_o=1 for exactly one cycle, between E16 and E17.
REQ-017 At E17 the FSM SHALL return to IDLE unconditionally.
REQ-018 The accept-to-ready latency SHALL be 16 cycles, and the minimum spacing between accepted requests SHALL be 18 edges.
REQ-019 res_o and quot_o SHALL become valid in the DONE cycle and SHALL hold until the next accepting edge.
REQ-020 Between the accepting edge and DONE, res_o and quot_o SHALL hold their previous values; intermediate values SHALL NOT be visible.
REQ-021 div_zero_o SHALL update together with res_o and hold with it.
REQ-022 modulo_start_i SHALL be ignored in CALC and DONE; the operation is not restarted and no operands are re-latched.
REQ-023 Operand changes on op_a_i/op_b_i after the accepting edge SHALL NOT affect the result.
REQ-024 If op_b = 0, CALC SHALL be skipped: E1 enters DONE with res_o=op_a, quot_o=16'hFFFF and div_zero_o=1, so latency is 1 cycle.
REQ-025 If op_a < op_b, the result SHALL be res_o=op_a and quot_o=0, still with 16-cycle latency.
REQ-026 The 17-bit internal compare SHALL prevent overflow for op_b >= 16'h8000.

Reset
REQ-027 rst=1 SHALL force state IDLE, counter 0, modulo_ready_o=0, busy_o=0, res_o=0, quot_o=0 and div_zero_o=0.
REQ-028 rst asserted mid-CALC or in DONE SHALL abort the operation with no ready pulse, and all outputs SHALL be reset at the next edge.
REQ-029 rst SHALL have priority over modulo_start_i on the same edge.

Verification
REQ-030 a=48, b=18 -> ready 16 cycles after accept, res=12, quot=2, div_zero=0.
REQ-031 a=7, b=0 -> ready 1 cycle after accept, res=7, quot=16'hFFFF, div_zero=1.
REQ-032 a=5, b=9 -> res=5, quot=0; a=16'hFFFF, b=1 -> res=0, quot=16'hFFFF; a=16'hFFFF, b=16'h8000 -> res=16'h7FFF, quot=1.
REQ-033 Start a=100, b=7, then pulse start with a=9, b=2 at cycle 5 -> exactly one ready pulse, res=2, quot=14.
REQ-034 Start a=100, b=7, then rst at cycle 8 -> no ready pulse, all outputs 0, next request a=10, b=4 returns res=2.
REQ-035 Back-to-back chain: 1071 mod 462 = 147, then 462 mod 147 = 21, then 147 mod 21 = 0, each issued the cycle after IDLE resumes -> three ready pulses with the correct results.
